// File: rtl/instr_cache_if.sv
// instr_cache_if -- CPU fetch port and backing-memory read port of the
// instruction cache, bundled into one interface.
//   en, pc, flush        : CPU -> cache (fetch enable, fetch address, invalidate)
//   instr, stall         : cache -> CPU (registered instruction, fetch-not-ready)
//   mem_req, mem_addr    : cache -> memory (single outstanding word read)
//   mem_ack, mem_rdata   : memory -> cache (read data strobe and word)
// Modport slave is the cache side; modport master is the CPU/memory side.
interface instr_cache_if;
  logic        en;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] instr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output en, pc, flush, mem_ack, mem_rdata,
    input  instr, stall, mem_req, mem_addr
  );

  modport slave (
    input  en, pc, flush, mem_ack, mem_rdata,
    output instr, stall, mem_req, mem_addr
  );
endinterface

// File: rtl/instr_cache.sv
// instr_cache -- direct-mapped instruction cache with a synchronous-ROM style
// one-cycle read latency and a word-at-a-time line refill from backing memory.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (control state only; tag/data
//          arrays keep their contents)
//   bus  : instr_cache_if.slave -- en/pc/flush in, instr/stall out,
//          mem_req/mem_addr out, mem_ack/mem_rdata in
module instr_cache #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  instr_cache_if.slave bus
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [OFF_W-1:0]       count_q, count_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [31:0]            instr_q, instr_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [IDX_W-1:0]       fill_idx_q, fill_idx_d;
  logic [TAG_W-1:0]       fill_tag_q, fill_tag_d;

  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [31:0]            data_q [NUM_LINES][LINE_WORDS];

  logic [OFF_W-1:0]       pc_off;
  logic [IDX_W-1:0]       pc_idx;
  logic [TAG_W-1:0]       pc_tag;
  logic                   hit;
  logic                   start_fill;
  logic                   fill_ack;
  logic                   last_ack;

  assign pc_off = bus.pc[2 +: OFF_W];
  assign pc_idx = bus.pc[2 + OFF_W +: IDX_W];
  assign pc_tag = bus.pc[31 -: TAG_W];

  // A line being refilled is never reported as a hit: hit requires IDLE.
  assign hit        = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  // Flush wins over a same-cycle miss, so no refill is launched that edge.
  assign start_fill = (state_q == IDLE) && bus.en && !hit && !bus.flush;
  // mem_req is only high in FILL, so gating with the state drops stray acks.
  assign fill_ack   = (state_q == FILL) && bus.mem_ack;
  assign last_ack   = fill_ack && (count_q == OFF_W'(LINE_WORDS - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_fill) state_d = FILL;
      FILL: if (last_ack)   state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.stall   = 1'b0;
    bus.mem_req = 1'b0;
    case (state_q)
      IDLE: bus.stall = bus.en && !hit;
      FILL: begin
        bus.stall   = 1'b1;
        bus.mem_req = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.instr    = instr_q;
  assign bus.mem_addr = mem_addr_q;

  // ---------------- datapath next values ----------------
  always_comb begin
    valid_d      = valid_q;
    count_d      = count_q;
    flush_pend_d = flush_pend_q;
    mem_addr_d   = mem_addr_q;
    fill_idx_d   = fill_idx_q;
    fill_tag_d   = fill_tag_q;
    instr_d      = (bus.en && hit) ? data_q[pc_idx][pc_off] : instr_q;

    if (state_q == IDLE) begin
      if (bus.flush) begin
        valid_d = '0;
      end else if (start_fill) begin
        // The line is invalidated up front so an abandoned fill leaves it dead.
        valid_d[pc_idx] = 1'b0;
        fill_idx_d      = pc_idx;
        fill_tag_d      = pc_tag;
        count_d         = '0;
        mem_addr_d      = {bus.pc[31:2+OFF_W], {(2+OFF_W){1'b0}}};
      end
    end else begin
      if (bus.flush) flush_pend_d = 1'b1;
      if (fill_ack) begin
        if (last_ack) begin
          // mem_addr keeps pointing at the last word fetched while IDLE.
          count_d      = '0;
          flush_pend_d = 1'b0;
          if (flush_pend_q || bus.flush) valid_d = '0;
          else                           valid_d[fill_idx_q] = 1'b1;
        end else begin
          count_d    = count_q + OFF_W'(1);
          mem_addr_d = mem_addr_q + 32'd4;
        end
      end
    end
  end

  // ---------------- control registers (reset) ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
      instr_q      <= '0;
      mem_addr_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      count_q      <= count_d;
      flush_pend_q <= flush_pend_d;
      instr_q      <= instr_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // ---------------- line storage and fill bookkeeping (no reset) ----------------
  always_ff @(posedge clk) begin
    fill_idx_q <= fill_idx_d;
    fill_tag_q <= fill_tag_d;
    if (fill_ack) data_q[fill_idx_q][count_q] <= bus.mem_rdata;
    if (last_ack) tag_q[fill_idx_q] <= fill_tag_q;
  end

endmodule

// File: tb/tb_instr_cache.sv
module tb_instr_cache;

  localparam int NL = 16;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_cache_if bus ();

  instr_cache #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which lines hold which tag, plus the last instruction
  // the CPU should see. Line contents are always the backing-memory words.
  bit          m_valid [NL];
  int unsigned m_tag   [NL];
  logic [31:0] exp_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / (4 * LW)) % NL);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / (4 * LW * NL);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU fetch of address a, run to completion (including any refills).
  task automatic fetch(input logic [31:0] a, input int ack_every, input bit toggle,
                       input int flush_word, input int rst_after, output int fills);
    bit          done;
    bit          fpend;
    bit          abandoned;
    bit          ack;
    int          w;
    int          tick;
    int          fill_cycles;
    logic [31:0] base;
    done  = 1'b0;
    fills = 0;
    for (int it = 0; it < 4 && !done; it++) begin
      bus.pc = a; bus.en = 1'b1; bus.flush = 1'b0;
      bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
      @(negedge clk);
      if (m_hit(a)) begin
        chk("hit_stall", 32'(bus.stall), 32'd0);
        chk("hit_mem_req", 32'(bus.mem_req), 32'd0);
        @(posedge clk); #1;
        exp_instr = mem_word(a);
        chk("hit_instr", bus.instr, exp_instr);
        done = 1'b1;
      end else begin
        chk("miss_stall", 32'(bus.stall), 32'd1);
        chk("miss_mem_req_idle", 32'(bus.mem_req), 32'd0);
        @(posedge clk); #1;
        fills++;
        m_valid[idx_of(a)] = 1'b0;
        chk("miss_instr_hold", bus.instr, exp_instr);
        base = a & ~32'(4 * LW - 1);
        w = 0; tick = 0; fill_cycles = 0; fpend = 1'b0; abandoned = 1'b0;
        while (w < LW) begin
          if (rst_after > 0 && w == rst_after) begin
            bus.mem_ack = 1'b0;
            #1 rst = 1'b1;
            #1;
            chk("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
            chk("rst_mid_instr", bus.instr, 32'd0);
            chk("rst_mid_mem_addr", bus.mem_addr, 32'd0);
            exp_instr = 32'd0;
            m_clear();
            @(posedge clk); #1;
            rst = 1'b0;
            abandoned = 1'b1;
            break;
          end
          tick++;
          ack = ((tick % ack_every) == 0);
          bus.mem_ack   = ack;
          bus.mem_rdata = ack ? mem_word(base + 32'(4 * w)) : $urandom;
          bus.flush     = (flush_word == w);
          if (toggle) begin
            bus.pc = $urandom & 32'hFFFF_FFFC;
            bus.en = 1'($urandom);
          end
          @(negedge clk);
          fill_cycles++;
          chk("fill_stall", 32'(bus.stall), 32'd1);
          chk("fill_mem_req", 32'(bus.mem_req), 32'd1);
          chk("fill_mem_addr", bus.mem_addr, base + 32'(4 * w));
          if (bus.flush) fpend = 1'b1;
          @(posedge clk); #1;
          chk("fill_instr_hold", bus.instr, exp_instr);
          if (ack) w++;
        end
        bus.flush = 1'b0;
        if (!abandoned) begin
          chk("fill_len", 32'(fill_cycles), 32'(LW * ack_every));
          chk("fill_end_mem_req", 32'(bus.mem_req), 32'd0);
          chk("fill_end_mem_addr", bus.mem_addr, base + 32'(4 * (LW - 1)));
          if (fpend) m_clear();
          else begin
            m_valid[idx_of(a)] = 1'b1;
            m_tag[idx_of(a)]   = tag_of(a);
          end
        end
        flush_word = -1;
        rst_after  = -1;
      end
    end
    chk("fetch_done", 32'(done), 32'd1);
  endtask

  initial begin
    int          n;
    logic [31:0] ra;
    logic [31:0] tags [3];
    tags[0] = 32'h0040_0000; tags[1] = 32'h0040_0100; tags[2] = 32'h1234_5600;
    m_clear();
    exp_instr = 32'd0;
    bus.en = 1'b0; bus.pc = 32'd0; bus.flush = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Cold miss, then sequential hits in the same line
    fetch(32'h0040_0000, 1, 1'b0, -1, -1, n);
    chk("cold_fills", 32'(n), 32'd1);
    fetch(32'h0040_0004, 1, 1'b0, -1, -1, n); chk("seq4_fills", 32'(n), 32'd0);
    fetch(32'h0040_0008, 1, 1'b0, -1, -1, n); chk("seq8_fills", 32'(n), 32'd0);
    fetch(32'h0040_000C, 1, 1'b0, -1, -1, n); chk("seqC_fills", 32'(n), 32'd0);

    // en low: instr holds, no stall, even on a resident address
    bus.en = 1'b0; bus.pc = 32'h0040_0008;
    @(negedge clk);
    chk("en0_stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    chk("en0_instr_hold", bus.instr, mem_word(32'h0040_000C));

    // Conflict eviction on index 0
    fetch(32'h0040_0100, 1, 1'b0, -1, -1, n); chk("evict_fills", 32'(n), 32'd1);
    fetch(32'h0040_0000, 1, 1'b0, -1, -1, n); chk("evict_back_fills", 32'(n), 32'd1);

    // Slow memory with pc/en churn during the fill
    fetch(32'h0040_0040, 3, 1'b1, -1, -1, n); chk("slow_fills", 32'(n), 32'd1);

    // Flush in IDLE beats a same-cycle miss
    bus.pc = 32'h0040_0300; bus.en = 1'b1; bus.flush = 1'b1; bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("flush_idle_stall", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    m_clear();
    chk("flush_idle_no_fill", 32'(bus.mem_req), 32'd0);
    fetch(32'h0040_0000, 1, 1'b0, -1, -1, n); chk("after_flush_fills", 32'(n), 32'd1);

    // Flush during word 2 of a fill: line ends invalid, same pc refills
    fetch(32'h0040_0010, 1, 1'b0, 2, -1, n); chk("flush_fill_fills", 32'(n), 32'd2);

    // Reset after two acks abandons the fill; a full refill follows
    fetch(32'h0040_0000, 1, 1'b0, -1, 2, n); chk("rst_fill_fills", 32'(n), 32'd2);

    // Randomised traffic over a few conflicting tags
    for (int k = 0; k < 40; k++) begin
      ra = tags[$urandom_range(0, 2)] | (32'($urandom_range(0, NL - 1)) << 4)
           | (32'($urandom_range(0, LW - 1)) << 2);
      if ($urandom_range(0, 3) == 0) begin
        bus.en = 1'b0; bus.pc = ra; bus.flush = 1'b0; bus.mem_ack = 1'b1;
        @(negedge clk);
        chk("rnd_en0_stall", 32'(bus.stall), 32'd0);
        chk("rnd_en0_mem_req", 32'(bus.mem_req), 32'd0);
        @(posedge clk); #1;
        chk("rnd_en0_instr", bus.instr, exp_instr);
      end else begin
        fetch(ra, $urandom_range(1, 3), 1'($urandom), -1, -1, n);
        chk("rnd_fills", 32'(n <= 1), 32'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
